// File: rtl/scaler_out_packer.sv
// Buffers the scaler's free-running pixel stream, tags each pixel with start-of-frame /
// end-of-line from the output raster position, and emits it on a valid/ready interface.
module scaler_out_packer #(
  parameter int OUT_WIDTH  = 1280,
  parameter int OUT_HEIGHT = 720,
  parameter int DEPTH      = 64,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   in_pixel,
  input  logic          in_valid,
  input  logic          frame_restart,
  input  logic          clr_ovf,
  output logic [23:0]   m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_eol,
  output logic          overflow,
  output logic [AW:0]   level
);

  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int RW = $clog2(OUT_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_HEIGHT - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic          wr;
  logic          tag_sof;
  logic          tag_eol;
  logic [25:0]   head;

  logic [25:0]   mem [DEPTH];

  // Raster position and tags: frame_restart retags the current pixel as (0,0)
  always_comb begin
    col_cur = frame_restart ? '0 : col_q;
    row_cur = frame_restart ? '0 : row_q;
    tag_sof = (col_cur == '0) && (row_cur == '0);
    tag_eol = (col_cur == COL_LAST);
    col_d   = col_cur;
    row_d   = row_cur;
    // Counters follow the scaler's raster even when the pixel is dropped
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  // FIFO control: a full FIFO still accepts a write when the head leaves this cycle
  always_comb begin
    pop      = (level_q != '0) && m_ready;
    wr       = in_valid && ((level_q != LVL_FULL) || pop);
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = clr_ovf ? 1'b0 : ovf_q;
    if (in_valid && !wr) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= {tag_sof, tag_eol, in_pixel};
  end

  // Show-ahead output: head entry is visible as soon as it is written
  always_comb begin
    head     = mem[rd_ptr_q];
    m_valid  = (level_q != '0);
    m_data   = m_valid ? head[23:0] : '0;
    m_eol    = m_valid & head[24];
    m_sof    = m_valid & head[25];
    overflow = ovf_q;
    level    = level_q;
  end

endmodule
